// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one word request at a time
// to instruction memory and buffers returned words in a FIFO toward decode.

module fetch_queue_checker #(
    parameter int DEPTH = 2
) (
    input logic clock,
    input logic reset,
    input logic push,
    input logic full
);

    // The issue rule reserves a slot before each request, so a full FIFO never sees a push
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && full));
        end
    end

endmodule

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [24:0] id_imm_field,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   target_pc_r;
    logic          req_active_r;
    logic          discard_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic          ack_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          room_s;
    logic [31:0]   redirect_aligned_s;
    logic [CW-1:0] count_next_s;
    logic [31:0]   fetch_pc_next_s;
    logic [31:0]   target_pc_next_s;
    logic          discard_next_s;

    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
    assign ack_s              = imem_ack && req_active_r;
    assign push_s             = ack_s && !discard_r && !redirect_valid;
    assign pop_s              = (count_r != CW'(0)) && id_ready && !redirect_valid;
    assign full_s             = (count_r == CW'(DEPTH));
    assign room_s             = (32'(count_next_s) + 32'd1) <= 32'(DEPTH);

    // Occupancy after this cycle's redirect, push and pop
    always_comb begin
        count_next_s = count_r;
        if (redirect_valid) begin
            count_next_s = CW'(0);
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Fetch PC tracking; a redirect during an outstanding request parks its target
    // until the stale ack returns, keeping imem_addr stable for the memory
    always_comb begin
        fetch_pc_next_s  = fetch_pc_r;
        target_pc_next_s = target_pc_r;
        discard_next_s   = discard_r;
        if (redirect_valid) begin
            if (req_active_r && !imem_ack) begin
                discard_next_s   = 1'b1;
                target_pc_next_s = redirect_aligned_s;
            end else begin
                discard_next_s  = 1'b0;
                fetch_pc_next_s = redirect_aligned_s;
            end
        end else if (ack_s && discard_r) begin
            discard_next_s  = 1'b0;
            fetch_pc_next_s = target_pc_r;
        end else if (ack_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // State registers and FIFO storage
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC;
            target_pc_r  <= RESET_PC;
            req_active_r <= 1'b0;
            discard_r    <= 1'b0;
            count_r      <= CW'(0);
            rd_ptr_r     <= PW'(0);
            wr_ptr_r     <= PW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_r   <= fetch_pc_next_s;
            target_pc_r  <= target_pc_next_s;
            req_active_r <= room_s;
            discard_r    <= discard_next_s;
            count_r      <= count_next_s;
            if (redirect_valid) begin
                rd_ptr_r <= PW'(0);
                wr_ptr_r <= PW'(0);
            end else begin
                if (push_s) begin
                    pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
                    instr_mem_r[wr_ptr_r] <= imem_rdata;
                    wr_ptr_r              <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end
        end
    end

    assign imem_req     = req_active_r;
    assign imem_addr    = fetch_pc_r;
    assign id_valid     = (count_r != CW'(0));
    assign empty        = (count_r == CW'(0));
    assign id_pc        = pc_mem_r[rd_ptr_r];
    assign id_instr     = instr_mem_r[rd_ptr_r];
    assign id_imm_field = id_instr[31:7];

    fetch_queue_checker #(.DEPTH(DEPTH)) u_checker (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .full  (full_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall, redirects, PC wrap and reset.
module tb_fetch_queue;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [24:0] id_imm_field;
    logic        empty;

    logic        auto_ack = 1'b1;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0000_0000;

    int checks = 0;
    int errors = 0;

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = auto_ack ? (imem_addr ^ K) : man_rdata;

    always #5 clock = ~clock;

    fetch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_imm_field   (id_imm_field),
        .empty          (empty)
    );

    task automatic tick;
        @(negedge clock);
    endtask

    // Leaves the bench at the first negedge after reset release (first request visible)
    task automatic do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        auto_ack = 1'b1;
        id_ready = 1'b1;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", id_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", empty); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", id_pc); end
        checks++; if (id_instr !== 32'h0 || id_imm_field !== 25'h0) begin errors++; $display("FAIL rst_instr got %h/%h want 0", id_instr, id_imm_field); end
        reset = 1'b0;
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %0b/%h want 1/0", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL first_latency got valid %0b want 0", id_valid); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== (32'(4 * i) ^ K)
                || imem_addr !== 32'(4 * (i + 1)) || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d] got v=%0b pc=%h instr=%h addr=%h req=%0b want v=1 pc=%h instr=%h addr=%h req=1",
                         i, id_valid, id_pc, id_instr, imem_addr, imem_req,
                         32'(4 * i), 32'(4 * i) ^ K, 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall;
        auto_ack = 1'b1;
        id_ready = 1'b0;
        do_reset;
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h8 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d] got req=%0b addr=%h pc=%h v=%0b want 0/8/0/1", i, imem_req, imem_addr, id_pc, id_valid);
            end
            tick;
        end
        auto_ack = 1'b0;
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        tick;
        man_ack = 1'b0;
        auto_ack = 1'b1;
        checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL idle_ack got addr=%h req=%0b pc=%h want 8/0/0", imem_addr, imem_req, id_pc); end
        id_ready = 1'b1;
        tick;
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_pc !== 32'h4) begin errors++; $display("FAIL resume got req=%0b addr=%h pc=%h want 1/8/4", imem_req, imem_addr, id_pc); end
        id_ready = 1'b1;
    endtask

    task automatic test_redirect_outstanding;
        auto_ack = 1'b0;
        man_ack = 1'b0;
        id_ready = 1'b1;
        do_reset;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick;
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || empty !== 1'b1) begin errors++; $display("FAIL hold_old got req=%0b addr=%h empty=%0b want 1/0/1", imem_req, imem_addr, empty); end
        tick;
        man_rdata = 32'h1111_2222;
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        checks++; if (empty !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL drop_old got empty=%0b v=%0b want 1/0", empty, id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
        man_rdata = 32'h0000_0100 ^ K;
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0100 || id_instr !== 32'hA5A5_0100) begin errors++; $display("FAIL redir_head got v=%0b pc=%h instr=%h want 1/100/a5a50100", id_valid, id_pc, id_instr); end
        auto_ack = 1'b1;
    endtask

    task automatic test_redirect_pop_ack;
        auto_ack = 1'b1;
        id_ready = 1'b1;
        do_reset;
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick;
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rpa_flush got v=%0b empty=%0b want 0/1", id_valid, empty); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rpa_addr got req=%0b addr=%h want 1/200", imem_req, imem_addr); end
        tick;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0200) begin errors++; $display("FAIL rpa_head got v=%0b pc=%h want 1/200", id_valid, id_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFFC;
        exp_pc[1] = 32'h0000_0000;
        exp_pc[2] = 32'h0000_0004;
        auto_ack = 1'b1;
        id_ready = 1'b1;
        do_reset;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || empty !== 1'b1) begin errors++; $display("FAIL wrap_addr got %h empty=%0b want fffffffc/1", imem_addr, empty); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== exp_pc[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%0b pc=%h want 1/%h", i, id_valid, id_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_imm_and_reset;
        auto_ack = 1'b0;
        man_ack = 1'b0;
        id_ready = 1'b0;
        do_reset;
        man_rdata = 32'hFFF0_0093;
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        checks++; if (id_instr !== 32'hFFF0_0093 || id_imm_field !== 25'h1FF_E001) begin errors++; $display("FAIL imm got instr=%h imm=%h want fff00093/1ffe001", id_instr, id_imm_field); end
        auto_ack = 1'b1;
        id_ready = 1'b1;
        tick;
        tick;
        reset = 1'b1;
        tick;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset got v=%0b req=%0b empty=%0b want 0/0/1", id_valid, imem_req, empty); end
        reset = 1'b0;
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
        tick;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== K) begin errors++; $display("FAIL restart_head got v=%0b pc=%h instr=%h want 1/0/a5a50000", id_valid, id_pc, id_instr); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect_outstanding;
        test_redirect_pop_ack;
        test_wrap;
        test_imm_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end: owns the fetch PC and issues word requests to instruction memory.
- Buffers returned words in a small FIFO and presents them to decode through a valid/ready handshake.
- Decode drives the immediate generator directly from id_instr[31:7], which is also exported as id_imm_field.
- Handles redirects from execute (branch/jump/trap) by flushing and refetching.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
DEPTH, 2, FIFO entries (power of two, 2..8).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  word-aligned request address, stable while imem_req && !imem_ack
imem_ack  input  1  memory accepted request and returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_ack
id_valid  output  1  head entry valid toward decode
id_ready  input  1  decode accepts head entry
id_pc  output  32  PC of head entry
id_instr  output  32  instruction of head entry
id_imm_field  output  25  id_instr[31:7], immediate source bits for decode
empty  output  1  FIFO holds no entries

Behaviour:
- Reset (reset=1 at edge): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, req_active=0, discard=0.
- Outputs while reset is held: imem_req=0, id_valid=0, empty=1, id_pc/id_instr/id_imm_field=0.
- Reset asserted mid-transaction abandons it: no push, and no ack is honoured in that cycle.
- imem_req = req_active (registered); imem_addr = fetch_pc.
- Request issue rule: req_active next = (count_next + 1 <= DEPTH) && !reset.
  - count_next includes this cycle's push/pop.
  - At most one request is outstanding.
  - Back-to-back requests are allowed: ack in cycle N with room remaining keeps imem_req=1 in cycle N+1 at fetch_pc+4.
- Ack with imem_req=1 and discard=0: push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^32).
- Ack while imem_req=0: ignored.
- Pop: id_valid && id_ready; head advances.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push to a full FIFO cannot occur, because the issue rule reserves the slot. Verify this with an assertion.
- id_valid = (count != 0); empty = (count == 0).
- Head outputs come straight from FIFO storage. Zero-latency bypass from imem_rdata to decode is not allowed.
- Latency: minimum 2 cycles from request issue to id_valid.
  - Issue in cycle N, ack in N → push at edge ending N → id_valid in N+1.
- Redirect (redirect_valid=1 at edge), which has priority over push and pop in the same cycle:
  - count=0, pointers=0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Same-cycle ack: data dropped.
  - Request still outstanding (imem_req=1, no ack this cycle): discard=1, imem_req stays 1 at the old address until acked. That ack is dropped, clears discard, and does not advance fetch_pc. The next request uses the redirect target.
  - No request outstanding: req_active=1 next cycle at the redirect target.
- Decode stall (id_ready=0) with FIFO full: imem_req drops to 0 and fetch_pc holds. Fetch resumes the cycle after the first pop.
- Redirect and reset in the same cycle: reset wins.

Test Plan:
- Reset release, RESET_PC=0, memory acks every cycle with rdata=addr^32'hA5A5_0000, id_ready=1 → imem_addr 0,4,8,… on consecutive cycles; id_pc=0 with id_instr=32'hA5A5_0000 one cycle after first ack; thereafter one entry per cycle in order.
- id_ready=0 from start → exactly 2 pushes (pc 0,4), imem_req=0, fetch_pc holds at 8; raise id_ready → pop pc 0, imem_req=1 at addr 8 next cycle.
- Memory ack delayed 3 cycles, redirect_pc=32'h0000_0103 asserted in the wait → old ack dropped, empty=1, next imem_addr=32'h0000_0100, first id_pc=32'h0000_0100.
- Redirect in the same cycle as pop and ack with the FIFO holding 1 entry → count=0 next cycle, acked word never appears, id_valid=0 for ≥1 cycle.
- redirect_pc=32'hFFFF_FFFC, acks every cycle → id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Instruction 32'hFFF0_0093 at head → id_imm_field=25'h1FFE001; reset asserted mid-stream → next cycle id_valid=0, imem_req=0, then restart at RESET_PC.
